// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register with stall/flush,
// alignment/range fault detection and a handshake counter.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] LAST_ADDR = 32'(IMEM_WORDS * 4 - 4);
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef enum logic {RUN, FAULT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic        advance, handshake, pc_legal;
  logic        do_fetch, do_trap;

  assign advance     = !if_valid || id_ready;
  assign handshake   = if_valid && id_ready;
  assign pc_legal    = (pc[1:0] == 2'b00) && (pc <= LAST_ADDR);
  assign imem_addr   = pc;
  assign if_pc_plus4 = if_pc + 32'd4;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Next-state logic: redirect always wins, illegal fetch traps
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (!redirect_valid && advance && !pc_legal) state_nxt = FAULT;
      FAULT:   if (redirect_valid) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Output / control decode
  always_comb begin
    fetch_fault = (state == FAULT);
    do_fetch    = (state == RUN) && !redirect_valid && advance && pc_legal;
    do_trap     = (state == RUN) && !redirect_valid && advance && !pc_legal;
  end

  // PC and IF/ID register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= NOP;
      if_pc    <= 32'h0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      if_valid <= 1'b0;
    end else if (do_fetch) begin
      pc       <= pc + 32'd4;
      if_valid <= 1'b1;
      if_instr <= imem_rdata;
      if_pc    <= pc;
    end else if (do_trap) begin
      // the held instruction may still be consumed this cycle; nothing replaces it
      if_valid <= 1'b0;
    end
  end

  // Handshakes are counted even when a redirect flushes the register the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         fetch_count <= 32'h0;
    else if (handshake) fetch_count <= fetch_count + 32'd1;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the fetch address loaded at reset.
REQ-002 Parameter IMEM_WORDS, default 64, SHALL be the number of 32-bit words in the downstream instruction memory; legal fetch range is byte addresses 0 .. IMEM_WORDS*4-4.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 imem_addr  output  32  SHALL be the byte address driven to instruction memory.
REQ-006 imem_rdata  input  32  SHALL be the word returned by instruction memory, combinational from imem_addr, same cycle.
REQ-007 redirect_valid  input  1  SHALL request a PC change (branch/jump/trap) this cycle.
REQ-008 redirect_pc  input  32  SHALL be the redirect target byte address.
REQ-009 id_ready  input  1  SHALL indicate decode accepts the IF/ID register contents this cycle.
REQ-010 if_valid  output  1  SHALL flag that if_instr/if_pc hold a valid fetched instruction.
REQ-011 if_instr  output  32  SHALL be the registered fetched instruction.
REQ-012 if_pc  output  32  SHALL be the address of if_instr.
REQ-013 if_pc_plus4  output  32  SHALL be if_pc + 4, combinational, modulo 2^32.
REQ-014 fetch_fault  output  1  SHALL flag a misaligned or out-of-range fetch address.
REQ-015 fetch_count  output  32  SHALL count instructions handed to decode.

Function
REQ-016 Internal pc register SHALL drive imem_addr directly (imem_addr = pc, no added latency).
REQ-017 State machine SHALL have two states: RUN, FAULT.
REQ-018 advance SHALL be defined as (!if_valid || id_ready); a handshake SHALL be (if_valid && id_ready).
REQ-019 RUN, no redirect, advance=1, pc legal: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4.
REQ-020 RUN, no redirect, advance=0: pc, if_instr, if_pc, if_valid SHALL hold (stall, no instruction lost or duplicated).
REQ-021 Redirect SHALL have priority over stall and advance: pc<=redirect_pc, if_valid<=0 (flush), regardless of id_ready; if_instr/if_pc hold.
REQ-022 First instruction at a redirect target SHALL appear at if_valid the cycle after the redirect cycle (one bubble).
REQ-023 pc is illegal when pc[1:0]!=0 or pc>IMEM_WORDS*4-4; in RUN with no redirect and advance=1 an illegal pc SHALL move to FAULT, set fetch_fault=1, leave if_valid=0 and pc unchanged.
REQ-024 FAULT: pc and if_valid=0 SHALL hold; fetch_fault SHALL stay 1 until a redirect is taken.
REQ-025 Redirect in FAULT SHALL load pc, clear fetch_fault, return to RUN; an illegal target re-enters FAULT on the next cycle's check.
REQ-026 pc+4 SHALL wrap modulo 2^32; a wrapped or overrun pc is caught by REQ-023, never fetched.
REQ-027 fetch_count SHALL increment by 1 on each handshake, wrap modulo 2^32, and not increment on a redirect-flushed entry.
REQ-028 Handshake and redirect in the same cycle: the handshaked instruction SHALL be counted; the register is flushed.

Reset
REQ-029 rst_n low SHALL immediately set pc=RESET_PC, state=RUN, if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=0, fetch_fault=0, fetch_count=0; if_pc_plus4 then reads 4.
REQ-030 Reset asserted mid-stall or mid-fault SHALL discard all state; first fetch from RESET_PC occurs on the first rising edge after rst_n deasserts.

Verification
REQ-031 Reset release, id_ready=1, memory words 0..3 = A,B,C,D -> if_valid rises 1 cycle after release; if_pc sequence 0,4,8,12 with if_instr A,B,C,D; fetch_count=4 after 4 handshakes.
REQ-032 Hold id_ready=0 for 3 cycles while if_pc=8 -> if_pc=8, if_instr=C stable, fetch_count unchanged; id_ready=1 -> next if_pc=12.
REQ-033 redirect_valid=1, redirect_pc=0x20, id_ready=0 -> next cycle if_valid=0; following cycle if_pc=0x20, if_instr=word 8.
REQ-034 redirect_pc=0x22 -> one cycle later fetch_fault=1, if_valid=0 held; redirect to 0x10 -> fetch_fault=0, if_pc=0x10 next cycle.
REQ-035 Sequential fetch reaching pc=0x100 with IMEM_WORDS=64 -> fetch_fault=1, last valid if_pc=0xFC, no fetch at 0x100.
REQ-036 Assert rst_n=0 asynchronously mid-stall -> outputs reach reset values before the next clk edge.
